// File: rtl/display_scheduler.sv
// Round-robin scheduler placing one of three latched RSA result bytes on the two-digit display.
// Optional preemption of the rotation by newly loaded sources: define DISP_PREEMPT_EN.
module display_scheduler #(
  parameter int DWELL_CYCLES = 100_000_000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [2:0]  src_valid,
  input  logic [23:0] src_data,
  output logic [2:0]  src_ack,
  input  logic        clear,
  input  logic        hold,
  output logic [7:0]  disp_value,
  output logic [1:0]  disp_sel,
  output logic        disp_blank,
  output logic [2:0]  led_src
);
  localparam int CW = $clog2(DWELL_CYCLES);
  localparam logic [CW-1:0] LAST = CW'(DWELL_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, SHOW, ADVANCE} state_t;

  state_t          state;
  logic [CW-1:0]   cnt;
  logic [2:0]      loaded;
  logic [2:0][7:0] data;
  logic [2:0]      acc;
  logic [2:0]      pre_mask;
  logic [1:0]      first_idx;
  logic [1:0]      next_idx;
  logic [1:0]      pre_idx;
  logic            preempt;
  logic            restart;

  function automatic logic [1:0] lowest(input logic [2:0] m);
    if (m[0])      return 2'd0;
    else if (m[1]) return 2'd1;
    else           return 2'd2;
  endfunction

  function automatic logic [2:0] onehot(input logic [1:0] s);
    return 3'b001 << s;
  endfunction

  function automatic logic [1:0] wrap_inc(input logic [1:0] s);
    return (s == 2'd2) ? 2'd0 : s + 2'd1;
  endfunction

  // Search order after the current index is cur+1, cur+2 (mod 3), falling back to cur.
  function automatic logic [1:0] after(input logic [1:0] cur, input logic [2:0] m);
    logic [1:0] n1;
    logic [1:0] n2;
    n1 = wrap_inc(cur);
    n2 = wrap_inc(n1);
    if (m[n1])      return n1;
    else if (m[n2]) return n2;
    else            return cur;
  endfunction

  always_comb begin
    acc       = src_valid & {3{~clear}};
    pre_mask  = acc & ~onehot(disp_sel);
    first_idx = lowest(loaded);
    pre_idx   = lowest(pre_mask);
    next_idx  = after(disp_sel, loaded);
  end

`ifdef DISP_PREEMPT_EN
  assign preempt = (state != IDLE) && !hold && (|pre_mask);
  assign restart = (state == SHOW) && !hold && acc[disp_sel];
`else
  assign preempt = 1'b0;
  assign restart = 1'b0;
`endif

  assign disp_value = data[disp_sel];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      cnt        <= '0;
      loaded     <= '0;
      data       <= '0;
      src_ack    <= '0;
      disp_sel   <= '0;
      disp_blank <= 1'b1;
      led_src    <= '0;
    end else begin
      src_ack <= acc;
      for (int i = 0; i < 3; i++) begin
        if (acc[i]) data[i] <= src_data[8*i +: 8];
      end
      loaded <= clear ? 3'b000 : (loaded | acc);

      if (clear) begin
        state      <= IDLE;
        cnt        <= '0;
        disp_blank <= 1'b1;
        led_src    <= '0;
      end else if (preempt) begin
        state    <= SHOW;
        cnt      <= '0;
        disp_sel <= pre_idx;
        led_src  <= onehot(pre_idx);
      end else begin
        case (state)
          IDLE: begin
            if (|loaded) begin
              state      <= SHOW;
              cnt        <= '0;
              disp_sel   <= first_idx;
              disp_blank <= 1'b0;
              led_src    <= onehot(first_idx);
            end
          end
          SHOW: begin
            if (restart) begin
              cnt <= '0;
            end else if (!hold) begin
              if (cnt == LAST) begin
                state <= ADVANCE;
                cnt   <= '0;
              end else begin
                cnt <= cnt + 1'b1;
              end
            end
          end
          // Outputs still show the old source here; the switch lands on the way out.
          ADVANCE: begin
            state    <= SHOW;
            disp_sel <= next_idx;
            led_src  <= onehot(next_idx);
          end
          default: state <= IDLE;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_display_scheduler.sv
// Self-checking bench for display_scheduler with DWELL_CYCLES=4; a slot-age reference
// model tracks which source should be visible and for how long.
module tb_display_scheduler;
  localparam int DW = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [2:0]  src_valid = '0;
  logic [23:0] src_data = '0;
  logic        clear = 1'b0;
  logic        hold = 1'b0;
  logic [2:0]  src_ack;
  logic [7:0]  disp_value;
  logic [1:0]  disp_sel;
  logic        disp_blank;
  logic [2:0]  led_src;

  int checks = 0;
  int passed = 0;

  display_scheduler #(.DWELL_CYCLES(DW)) dut (
    .clk(clk), .rst_n(rst_n), .src_valid(src_valid), .src_data(src_data),
    .src_ack(src_ack), .clear(clear), .hold(hold), .disp_value(disp_value),
    .disp_sel(disp_sel), .disp_blank(disp_blank), .led_src(led_src)
  );

  always #5 clk = ~clk;

  // Reference model: which sources hold a value, which one is on screen, and how many
  // cycles the current slot has aged (age DW is the one-cycle hand-over).
  logic [7:0] m_data [3];
  logic [2:0] m_loaded;
  logic [2:0] m_ack;
  logic       m_showing;
  int         m_sel;
  int         m_age;

  function automatic int lowest_of(input logic [2:0] m);
    for (int i = 0; i < 3; i++) if (m[i]) return i;
    return 0;
  endfunction

  function automatic int next_after(input int cur, input logic [2:0] m);
    for (int k = 1; k < 3; k++) if (m[(cur + k) % 3]) return (cur + k) % 3;
    return cur;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 3; i++) m_data[i] = 8'd0;
    m_loaded = '0; m_ack = '0; m_showing = 1'b0; m_sel = 0; m_age = 0;
  endtask

  task automatic model_edge(input logic [2:0] v, input logic [23:0] d, input logic c, input logic h);
    logic [2:0] old;
    logic       moved;
    old = m_loaded;
    moved = 1'b0;
    if (c) begin
      m_ack = '0; m_loaded = '0; m_showing = 1'b0; m_age = 0;
    end else begin
      m_ack = v;
      for (int i = 0; i < 3; i++) if (v[i]) m_data[i] = d[8*i +: 8];
      if (!m_showing) begin
        if (old != 0) begin m_showing = 1'b1; m_sel = lowest_of(old); m_age = 0; end
      end else begin
`ifdef DISP_PREEMPT_EN
        if (!h && ((v & ~(3'b001 << m_sel)) != 0)) begin
          m_sel = lowest_of(v & ~(3'b001 << m_sel)); m_age = 0; moved = 1'b1;
        end else if (!h && v[m_sel] && m_age < DW) begin
          m_age = 0; moved = 1'b1;
        end
`endif
        if (!moved) begin
          if (m_age == DW) begin m_sel = next_after(m_sel, old); m_age = 0; end
          else if (!h) m_age++;
        end
      end
      m_loaded = old | v;
    end
  endtask

  function automatic logic [16:0] model_out();
    logic [2:0] led;
    led = m_showing ? 3'(3'b001 << m_sel) : 3'b000;
    return {m_ack, m_data[m_sel], 2'(m_sel), ~m_showing, led};
  endfunction

  task automatic step(input logic [2:0] v, input logic [23:0] d, input logic c, input logic h);
    src_valid = v; src_data = d; clear = c; hold = h;
    @(posedge clk);
    model_edge(v, d, c, h);
    #1;
    src_valid = '0; clear = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({src_ack, disp_value, disp_sel, disp_blank, led_src} !== {3'b000, 8'd0, 2'd0, 1'b1, 3'b000})
      $display("FAIL reset_state: got ack=%b val=%0d sel=%0d blank=%b led=%b want 000/0/0/1/000",
               src_ack, disp_value, disp_sel, disp_blank, led_src);
    else passed++;
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      step(3'b000, 24'h0, 1'b0, 1'b0);
      checks++;
      if ({src_ack, disp_value, disp_blank, led_src} !== {3'b000, 8'd0, 1'b1, 3'b000})
        $display("FAIL idle_after_reset[%0d]: got ack=%b val=%0d blank=%b led=%b want 000/0/1/000",
                 i, src_ack, disp_value, disp_blank, led_src);
      else passed++;
    end
  endtask

  task automatic test_single_source();
    step(3'b010, {8'd0, 8'd42, 8'd0}, 1'b0, 1'b0);
    checks++;
    if (src_ack !== 3'b010) $display("FAIL single_ack: got %b want 010", src_ack);
    else passed++;
    step(3'b000, 24'h0, 1'b0, 1'b0);
    checks++;
    if ({src_ack, disp_sel, disp_value, disp_blank, led_src} !== {3'b000, 2'd1, 8'd42, 1'b0, 3'b010})
      $display("FAIL single_show: got ack=%b sel=%0d val=%0d blank=%b led=%b want 000/1/42/0/010",
               src_ack, disp_sel, disp_value, disp_blank, led_src);
    else passed++;
    for (int i = 0; i < 20; i++) begin
      step(3'b000, 24'h0, 1'b0, 1'b0);
      checks++;
      if ({disp_sel, disp_value, disp_blank} !== {2'd1, 8'd42, 1'b0})
        $display("FAIL single_stays[%0d]: got sel=%0d val=%0d blank=%b want 1/42/0",
                 i, disp_sel, disp_value, disp_blank);
      else passed++;
    end
  endtask

  task automatic test_rotation();
    logic [7:0] vals [3];
    vals[0] = 8'd7; vals[1] = 8'd42; vals[2] = 8'd99;
    step(3'b000, 24'h0, 1'b1, 1'b0);
    step(3'b111, {8'd99, 8'd42, 8'd7}, 1'b0, 1'b0);
    for (int k = 0; k < 20; k++) begin
      step(3'b000, 24'h0, 1'b0, 1'b0);
      checks++;
      if (disp_value !== vals[(k / 5) % 3])
        $display("FAIL rotation[%0d]: got %0d want %0d", k, disp_value, vals[(k / 5) % 3]);
      else passed++;
    end
  endtask

  task automatic test_hold();
    int budget;
    step(3'b000, 24'h0, 1'b1, 1'b0);
    step(3'b111, {8'd99, 8'd42, 8'd7}, 1'b0, 1'b0);
    budget = 0;
    while (!(disp_sel == 2'd1 && !disp_blank) && budget < 20) begin
      step(3'b000, 24'h0, 1'b0, 1'b0);
      budget++;
    end
    checks++;
    if (budget >= 20) $display("FAIL hold_reach_42: got sel=%0d want 1 within 20 cycles", disp_sel);
    else passed++;
    step(3'b000, 24'h0, 1'b0, 1'b0);
    for (int i = 0; i < 20; i++) begin
      step(3'b000, 24'h0, 1'b0, 1'b1);
      checks++;
      if (disp_value !== 8'd42) $display("FAIL hold_frozen[%0d]: got %0d want 42", i, disp_value);
      else passed++;
    end
    for (int i = 1; i <= 4; i++) begin
      step(3'b000, 24'h0, 1'b0, 1'b0);
      if (i >= 3) begin
        checks++;
        if (disp_value !== ((i == 4) ? 8'd99 : 8'd42))
          $display("FAIL hold_release[%0d]: got %0d want %0d", i, disp_value, (i == 4) ? 99 : 42);
        else passed++;
      end
    end
  endtask

  task automatic test_clear_priority();
    step(3'b001, 24'h000011, 1'b1, 1'b0);
    checks++;
    if (src_ack !== 3'b000) $display("FAIL clear_no_ack: got %b want 000", src_ack);
    else passed++;
    step(3'b000, 24'h0, 1'b0, 1'b0);
    checks++;
    if ({src_ack, disp_blank, led_src} !== {3'b000, 1'b1, 3'b000})
      $display("FAIL clear_blank: got ack=%b blank=%b led=%b want 000/1/000", src_ack, disp_blank, led_src);
    else passed++;
    repeat (3) step(3'b000, 24'h0, 1'b0, 1'b0);
    checks++;
    if (disp_blank !== 1'b1) $display("FAIL clear_valid_ignored: got blank=%b want 1", disp_blank);
    else passed++;
  endtask

  task automatic test_preempt();
    step(3'b000, 24'h0, 1'b1, 1'b0);
    step(3'b001, {8'd0, 8'd0, 8'd7}, 1'b0, 1'b0);
    step(3'b000, 24'h0, 1'b0, 1'b0);
    step(3'b000, 24'h0, 1'b0, 1'b0);
    step(3'b100, {8'd55, 8'd0, 8'd0}, 1'b0, 1'b0);
`ifdef DISP_PREEMPT_EN
    checks++;
    if ({disp_sel, disp_value} !== {2'd2, 8'd55})
      $display("FAIL preempt_switch: got sel=%0d val=%0d want 2/55", disp_sel, disp_value);
    else passed++;
`else
    for (int i = 0; i < 4; i++) begin
      if (i > 0) step(3'b000, 24'h0, 1'b0, 1'b0);
      checks++;
      if (disp_value !== ((i == 3) ? 8'd55 : 8'd7))
        $display("FAIL no_preempt[%0d]: got %0d want %0d", i, disp_value, (i == 3) ? 55 : 7);
      else passed++;
    end
`endif
  endtask

  task automatic test_random();
    logic [2:0]  v;
    logic [16:0] exp;
    for (int n = 0; n < 400; n++) begin
      v = ($urandom_range(0, 5) == 0) ? 3'($urandom_range(1, 7)) : 3'b000;
      step(v, 24'($urandom), ($urandom_range(0, 40) == 0), ($urandom_range(0, 5) == 0));
      exp = model_out();
      checks++;
      if ({src_ack, disp_value, disp_sel, disp_blank, led_src} !== exp)
        $display("FAIL random[%0d]: got ack=%b val=%0d sel=%0d blank=%b led=%b want ack=%b val=%0d sel=%0d blank=%b led=%b",
                 n, src_ack, disp_value, disp_sel, disp_blank, led_src,
                 exp[16:14], exp[13:6], exp[5:4], exp[3], exp[2:0]);
      else passed++;
    end
  endtask

  task automatic test_async_reset();
    step(3'b000, 24'h0, 1'b1, 1'b0);
    step(3'b111, {8'd3, 8'd2, 8'd1}, 1'b0, 1'b0);
    repeat (3) step(3'b000, 24'h0, 1'b0, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({src_ack, disp_value, disp_sel, disp_blank, led_src} !== {3'b000, 8'd0, 2'd0, 1'b1, 3'b000})
      $display("FAIL async_reset: got ack=%b val=%0d sel=%0d blank=%b led=%b want 000/0/0/1/000",
               src_ack, disp_value, disp_sel, disp_blank, led_src);
    else passed++;
    model_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (3) step(3'b000, 24'h0, 1'b0, 1'b0);
    checks++;
    if (disp_blank !== 1'b1) $display("FAIL async_reset_idle: got blank=%b want 1", disp_blank);
    else passed++;
  endtask

  initial begin
    model_reset();
    test_reset();
    test_single_source();
    test_rotation();
    test_hold();
    test_clear_priority();
    test_preempt();
    test_random();
    test_async_reset();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
